// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM host-port arbiter.
// FSM encoding, default widths and the round-robin pointer width helper.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_e;

    localparam int DEF_NUM_PORTS    = 4;
    localparam int DEF_HADDR_WIDTH  = 24;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_BUSY_TIMEOUT = 64;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Host-side bus between the arbiter (master) and sdram_controller (slave).
interface sdram_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int HADDR_WIDTH = DEF_HADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
);
    logic [HADDR_WIDTH-1:0] haddr;
    logic [DATA_WIDTH-1:0]  data_input;
    logic [DATA_WIDTH-1:0]  data_output;
    logic                   busy;
    logic                   rd_enable;
    logic                   wr_enable;

    modport master (
        output haddr, data_input, rd_enable, wr_enable,
        input  data_output, busy
    );

    modport slave (
        input  haddr, data_input, rd_enable, wr_enable,
        output data_output, busy
    );
endinterface

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1.
module sdram_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int PW        = ptr_width(DEF_NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PW-1:0]        gnt_idx,
    output logic                 any
);

    int idx_s;

    // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx_s   = 0;
        for (int off = NUM_PORTS; off >= 1; off--) begin
            idx_s = (int'(ptr) + off) % NUM_PORTS;
            if (req[idx_s]) begin
                gnt        = '0;
                gnt[idx_s] = 1'b1;
                gnt_idx    = PW'(idx_s);
                any        = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing the single-port sdram_controller host bus.
// Optional busy-timeout watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS    = DEF_NUM_PORTS,
    parameter int HADDR_WIDTH  = DEF_HADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              req,
    input  logic [NUM_PORTS-1:0]              req_we,
    input  logic [NUM_PORTS*HADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]              req_ack,
    output logic [NUM_PORTS-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    sdram_arbiter_if.master                   host,
    output logic                              arb_err
);

    localparam int PW = ptr_width(NUM_PORTS);
    localparam logic [PW-1:0] PTR_RST = PW'(NUM_PORTS - 1);

    arb_state_e             state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic                   we_q, we_d;
    logic [NUM_PORTS-1:0]   req_ack_q, req_ack_d;
    logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [DATA_WIDTH-1:0]  data_input_q, data_input_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   arb_err_q, arb_err_d;
`endif

    logic [NUM_PORTS-1:0]   gnt_s;
    logic [PW-1:0]          gnt_idx_s;
    logic                   any_s;

    sdram_rr_pick #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    // Next-state and next-output logic for the single-outstanding-operation FSM.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        we_d         = we_q;
        req_ack_d    = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        haddr_d      = haddr_q;
        data_input_d = data_input_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        arb_err_d    = arb_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A busy controller (refresh) must not be handed a new command.
                if (any_s && !host.busy) begin
                    haddr_d      = req_addr[int'(gnt_idx_s)*HADDR_WIDTH +: HADDR_WIDTH];
                    data_input_d = req_wdata[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                    we_d         = req_we[gnt_idx_s];
                    rd_en_d      = ~req_we[gnt_idx_s];
                    wr_en_d      = req_we[gnt_idx_s];
                    req_ack_d    = gnt_s;
                    ptr_d        = gnt_idx_s;
                    state_d      = ST_ISSUE;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (host.busy) begin
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    state_d = ST_WAIT_DONE;
`ifdef SDRAM_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    rd_en_d            = 1'b0;
                    wr_en_d            = 1'b0;
                    arb_err_d          = 1'b1;
                    rsp_valid_d[ptr_q] = 1'b1;
                    state_d            = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`else
                end else begin
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_WAIT_DONE: begin
                if (!host.busy) begin
                    if (!we_q) begin
                        rsp_rdata_d = host.data_output;
                    end else begin
                        rsp_rdata_d = rsp_rdata_q;
                    end
                    rsp_valid_d[ptr_q] = 1'b1;
                    state_d            = ST_RESP;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= PTR_RST;
            we_q         <= 1'b0;
            req_ack_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            haddr_q      <= '0;
            data_input_q <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            arb_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            we_q         <= we_d;
            req_ack_q    <= req_ack_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            haddr_q      <= haddr_d;
            data_input_q <= data_input_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            arb_err_q    <= arb_err_d;
`endif
        end
    end

    assign req_ack         = req_ack_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign host.haddr      = haddr_q;
    assign host.data_input = data_input_q;
    assign host.rd_enable  = rd_en_q;
    assign host.wr_enable  = wr_en_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
    assign arb_err         = arb_err_q;
`else
    assign arb_err         = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: controller model, vector table and scoreboard.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int NP = 4;
    localparam int AW = 24;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [NP-1:0]    req = '0, req_we = '0;
    logic [NP*AW-1:0] req_addr = '0;
    logic [NP*DW-1:0] req_wdata = '0;
    logic [NP-1:0]    req_ack, rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             arb_err;

    sdram_arbiter_if #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW)) host_if ();

    sdram_arbiter #(.NUM_PORTS(NP), .HADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUSY_TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .host      (host_if),
        .arb_err   (arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        port;
        logic      we;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    typedef struct {
        int        port;
        logic      we;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        bit        chk_bus;
    } exp_t;

    exp_t sb[$];
    int   ack_log[$];
    int   checks = 0, errors = 0;
    int   overlap = 0, hold_err = 0, ops = 0;
    int   ref_req = 0, ref_seen = 0;
    bit   m_never = 1'b0;
    logic [15:0] last_rd = 16'h0000;
    logic [23:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic        m_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [23:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // Controller model: busy rises 2 cycles after an enable, stays high 6 cycles.
    initial begin
        int delay, hold, refresh;
        delay = 0; hold = 0; refresh = 0;
        host_if.busy        = 1'b0;
        host_if.data_output = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                host_if.busy = 1'b0; delay = 0; hold = 0; refresh = 0;
            end else if (ref_req != ref_seen) begin
                ref_seen = ref_req; refresh = 20; host_if.busy = 1'b1;
            end else if (refresh > 0) begin
                refresh--;
                if (refresh == 0) host_if.busy = 1'b0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) begin
                    host_if.busy        = 1'b0;
                    host_if.data_output = exp_rd(m_addr);
                end
            end else if (delay > 0) begin
                if (!(host_if.rd_enable || host_if.wr_enable)) hold_err++;
                delay--;
                if (delay == 0) begin host_if.busy = 1'b1; hold = 6; end
            end else if (!m_never && (host_if.rd_enable || host_if.wr_enable)) begin
                m_addr = host_if.haddr; m_wdata = host_if.data_input;
                m_we = host_if.wr_enable; delay = 1; ops++;
            end
        end
    end

    // Output monitor: scoreboard pop on rsp_valid, grant log, enable exclusivity.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (host_if.rd_enable && host_if.wr_enable) overlap++;
            if (req_ack != '0) begin
                check("ack_onehot", 32'($countones(req_ack)), 32'd1);
                for (int i = 0; i < NP; i++) if (req_ack[i]) ack_log.push_back(i);
            end
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_port", 32'(rsp_valid), 32'(1 << e.port));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    if (e.chk_bus) begin
                        check("bus_addr", 32'(m_addr), 32'(e.addr));
                        check("bus_we", 32'(m_we), 32'(e.we));
                        if (e.we) check("bus_wdata", 32'(m_wdata), 32'(e.wdata));
                    end
                end
            end
        end
    end

    task automatic set_port(input int p, input logic we, input logic [23:0] a, input logic [15:0] d);
        req_we[p] = we;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*DW +: DW] = d;
    endtask

    task automatic push_exp(input int p, input logic we, input logic [23:0] a,
                            input logic [15:0] d, input logic [15:0] rd, input bit bus);
        exp_t e;
        e.port = p; e.we = we; e.addr = a; e.wdata = d; e.rdata = rd; e.chk_bus = bus;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int p, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (req_ack == '0 && n < 60);
        check("ack_port", 32'(req_ack), 32'(1 << p));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); #1; n++; end
        check("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_op(input vec_t v);
        int n;
        @(negedge clk);
        set_port(v.port, v.we, v.addr, v.wdata);
        req[v.port] = 1'b1;
        push_exp(v.port, v.we, v.addr, v.wdata, v.rdata, 1'b1);
        wait_ack(v.port, n);
        check("ack_latency", 32'(n), 32'd1);
        req[v.port] = 1'b0;
        set_port(v.port, ~v.we, ~v.addr, ~v.wdata);
        wait_drain();
    endtask

    vec_t vecs[8];

    initial begin
        int n, cnt, grants, ops0;
        vecs[0] = '{2, 1'b0, 24'h012345, 16'h0000, 16'h86E0};
        vecs[1] = '{0, 1'b1, 24'h000010, 16'hBEEF, 16'h86E0};
        vecs[2] = '{0, 1'b0, 24'h000010, 16'h0000, 16'hA5B5};
        vecs[3] = '{3, 1'b0, 24'hFFFFFF, 16'h0000, 16'h5A5A};
        vecs[4] = '{1, 1'b1, 24'h00ABCD, 16'h1234, 16'h5A5A};
        vecs[5] = '{1, 1'b0, 24'h000000, 16'h0000, 16'hA5A5};
        vecs[6] = '{3, 1'b1, 24'h800000, 16'h0000, 16'hA5A5};
        vecs[7] = '{2, 1'b0, 24'h00A5A5, 16'h0000, 16'h0000};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ack", 32'(req_ack), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_haddr", 32'(host_if.haddr), 32'd0);
        check("rst_data_input", 32'(host_if.data_input), 32'd0);
        check("rst_rd_enable", 32'(host_if.rd_enable), 32'd0);
        check("rst_wr_enable", 32'(host_if.wr_enable), 32'd0);
        check("rst_arb_err", 32'(arb_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round-robin: all ports hold req for 8 operations.
        ack_log.delete();
        for (int p = 0; p < NP; p++) set_port(p, p[0], 24'h100000 + 24'(p) * 24'h001111, 16'hC000 + 16'(p));
        for (int i = 0; i < 8; i++) begin
            int p;
            logic [23:0] a;
            p = i % NP;
            a = 24'h100000 + 24'(p) * 24'h001111;
            if (p[0] == 1'b0) last_rd = exp_rd(a);
            push_exp(p, p[0], a, 16'hC000 + 16'(p), last_rd, 1'b1);
        end
        req = '1;
        cnt = 0; n = 0;
        while (cnt < 8 && n < 400) begin
            @(negedge clk); n++;
            if (rsp_valid != '0) cnt++;
            if (cnt == 8) req = '0;
        end
        req = '0;
        check("rr_count", 32'(cnt), 32'd8);
        check("rr_log_size", 32'(ack_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < ack_log.size(); i++)
            check("rr_grant", 32'(ack_log[i]), 32'(i % NP));
        wait_drain();

        for (int i = 0; i < 8; i++) run_op(vecs[i]);
        last_rd = 16'h0000;

        // Refresh stall: busy held high before the request arrives.
        ops0 = ops;
        @(posedge clk); ref_req++;
        repeat (2) @(negedge clk);
        #1;
        check("refresh_busy", 32'(host_if.busy), 32'd1);
        set_port(1, 1'b0, 24'h000321, 16'h0000);
        req[1] = 1'b1;
        push_exp(1, 1'b0, 24'h000321, 16'h0000, exp_rd(24'h000321), 1'b1);
        grants = 0;
        repeat (15) begin @(negedge clk); if (req_ack != '0 || host_if.rd_enable) grants++; end
        check("refresh_no_grant", 32'(grants), 32'd0);
        wait_ack(1, n);
        req[1] = 1'b0;
        wait_drain();
        check("refresh_ops", 32'(ops - ops0), 32'd1);

        // Reset during WAIT_DONE: outputs clear asynchronously, no response.
        @(negedge clk);
        set_port(2, 1'b0, 24'h00FF00, 16'h0000);
        req[2] = 1'b1;
        wait_ack(2, n);
        req[2] = 1'b0;
        n = 0;
        while (!host_if.busy && n < 20) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_haddr", 32'(host_if.haddr), 32'd0);
        check("mid_rst_rd_enable", 32'(host_if.rd_enable), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_req_ack", 32'(req_ack), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(vecs[0]);
        last_rd = vecs[0].rdata;

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Timeout: model never answers, enable must drop after 8 ISSUE cycles.
        m_never = 1'b1;
        @(negedge clk);
        set_port(1, 1'b0, 24'h000777, 16'h0000);
        req[1] = 1'b1;
        push_exp(1, 1'b0, 24'h000777, 16'h0000, last_rd, 1'b0);
        wait_ack(1, n);
        req[1] = 1'b0;
        cnt = 1;
        n = 0;
        while (n < 100) begin
            @(negedge clk); n++;
            if (host_if.rd_enable) cnt++;
            else break;
        end
        check("timeout_cycles", 32'(cnt), 32'd8);
        check("timeout_rsp", 32'(rsp_valid), 32'd2);
        check("timeout_err", 32'(arb_err), 32'd1);
        wait_drain();
        m_never = 1'b0;
        run_op(vecs[5]);
        check("timeout_err_sticky", 32'(arb_err), 32'd1);
`else
        check("arb_err_tied", 32'(arb_err), 32'd0);
`endif

        check("enable_overlap", 32'(overlap), 32'd0);
        check("enable_hold", 32'(hold_err), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
